// File: rtl/pred_resolve_queue_pkg.sv
// Shared BPU definitions for the predicted-branch resolve queue: entry layout,
// default depth and small helpers for packing and reading entries.
package pred_resolve_queue_pkg;

  localparam int DEPTH_DEFAULT = 4;
  localparam int ENTRY_W       = 3;

  localparam int SEL_BIT   = 0;
  localparam int PRED0_BIT = 1;
  localparam int PRED1_BIT = 2;

  typedef logic [ENTRY_W-1:0] entry_t;

  function automatic entry_t packEntry(input logic pred1, input logic pred0, input logic sel);
    entry_t e;
    e            = '0;
    e[PRED1_BIT] = pred1;
    e[PRED0_BIT] = pred0;
    e[SEL_BIT]   = sel;
    return e;
  endfunction

  // Direction that fetch actually followed for this entry.
  function automatic logic selectedPred(input entry_t e);
    return e[SEL_BIT] ? e[PRED1_BIT] : e[PRED0_BIT];
  endfunction

endpackage

// File: rtl/pred_resolve_queue_resolve_fifo.sv
// Entry storage and wrapping read/write pointers for the resolve queue.
// Flush clears occupancy on the next edge; entry contents are never reset.
module resolve_fifo
  import pred_resolve_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [ENTRY_W-1:0]     wr_data_i,
  input  logic                   rd_en_i,
  input  logic                   flush_i,
  output logic [ENTRY_W-1:0]     rd_data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // DEPTH is a power of two, so plain pointer overflow gives the modulo wrap.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (wr_en_i) wrPtr_d = wrPtr_q + PTR_W'(1);
      if (rd_en_i) rdPtr_d = rdPtr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en_i) - CNT_W'(rd_en_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wrPtr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rdPtr_q];
  assign count_o   = count_q;
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/pred_resolve_queue.sv
// Holds in-flight predicted branches and scores both predictors when execute resolves them.
// Optional macro PRED_RESOLVE_STATS_EN adds resolved/mispredict event counters.
module pred_resolve_queue
  import pred_resolve_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   in_Clk,
  input  logic                   in_Rst,
  input  logic                   in_push,
  input  logic                   in_pred0,
  input  logic                   in_pred1,
  input  logic                   in_sel,
  input  logic                   in_resolve,
  input  logic                   in_taken,
  input  logic                   in_flush,
  output logic [1:0]             out_hit,
  output logic                   out_hit_valid,
  output logic                   out_mispredict,
  output logic                   out_full,
  output logic                   out_empty,
  output logic [$clog2(DEPTH):0] out_count
`ifdef PRED_RESOLVE_STATS_EN
  ,
  output logic [31:0]            out_resolved_cnt,
  output logic [31:0]            out_mispred_cnt
`endif
);

  entry_t headEntry;
  logic   resolveOk;
  logic   pushOk;

  logic [1:0] hit_q, hit_d;
  logic       hitValid_q, hitValid_d;
  logic       mispred_q, mispred_d;

  // A full queue still takes a push when the head leaves in the same cycle.
  assign resolveOk = in_resolve & ~out_empty;
  assign pushOk    = in_push & ~in_flush & (~out_full | in_resolve);

  resolve_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (in_Clk),
    .rst_i    (in_Rst),
    .wr_en_i  (pushOk),
    .wr_data_i(packEntry(in_pred1, in_pred0, in_sel)),
    .rd_en_i  (resolveOk),
    .flush_i  (in_flush),
    .rd_data_o(headEntry),
    .count_o  (out_count),
    .full_o   (out_full),
    .empty_o  (out_empty)
  );

  always_comb begin
    hit_d      = hit_q;
    mispred_d  = mispred_q;
    hitValid_d = resolveOk;
    if (resolveOk) begin
      hit_d[1]  = (headEntry[PRED1_BIT] == in_taken);
      hit_d[0]  = (headEntry[PRED0_BIT] == in_taken);
      mispred_d = (selectedPred(headEntry) != in_taken);
    end
  end

  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      hit_q      <= 2'b00;
      hitValid_q <= 1'b0;
      mispred_q  <= 1'b0;
    end else begin
      hit_q      <= hit_d;
      hitValid_q <= hitValid_d;
      mispred_q  <= mispred_d;
    end
  end

  assign out_hit        = hit_q;
  assign out_hit_valid  = hitValid_q;
  assign out_mispredict = mispred_q;

`ifdef PRED_RESOLVE_STATS_EN
  logic [31:0] resolvedCnt_q;
  logic [31:0] mispredCnt_q;

  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      resolvedCnt_q <= '0;
      mispredCnt_q  <= '0;
    end else if (resolveOk) begin
      resolvedCnt_q <= resolvedCnt_q + 32'd1;
      if (mispred_d) mispredCnt_q <= mispredCnt_q + 32'd1;
    end
  end

  assign out_resolved_cnt = resolvedCnt_q;
  assign out_mispred_cnt  = mispredCnt_q;
`endif

endmodule

// File: tb/tb_pred_resolve_queue.sv
// Randomised and directed bench for pred_resolve_queue against a queue-based reference.
module tb_pred_resolve_queue;

  localparam int DEPTH = 4;

  logic       in_Clk;
  logic       in_Rst;
  logic       in_push;
  logic       in_pred0;
  logic       in_pred1;
  logic       in_sel;
  logic       in_resolve;
  logic       in_taken;
  logic       in_flush;
  logic [1:0] out_hit;
  logic       out_hit_valid;
  logic       out_mispredict;
  logic       out_full;
  logic       out_empty;
  logic [$clog2(DEPTH):0] out_count;
`ifdef PRED_RESOLVE_STATS_EN
  logic [31:0] out_resolved_cnt;
  logic [31:0] out_mispred_cnt;
`endif

  pred_resolve_queue #(
    .DEPTH(DEPTH)
  ) dut (
    .in_Clk        (in_Clk),
    .in_Rst        (in_Rst),
    .in_push       (in_push),
    .in_pred0      (in_pred0),
    .in_pred1      (in_pred1),
    .in_sel        (in_sel),
    .in_resolve    (in_resolve),
    .in_taken      (in_taken),
    .in_flush      (in_flush),
    .out_hit       (out_hit),
    .out_hit_valid (out_hit_valid),
    .out_mispredict(out_mispredict),
    .out_full      (out_full),
    .out_empty     (out_empty),
    .out_count     (out_count)
`ifdef PRED_RESOLVE_STATS_EN
    ,
    .out_resolved_cnt(out_resolved_cnt),
    .out_mispred_cnt (out_mispred_cnt)
`endif
  );

  initial begin
    in_Clk = 1'b0;
    forever #5 in_Clk = ~in_Clk;
  end

  int vectors    = 0;
  int miscompares = 0;

  // Reference state: each entry is {pred1, pred0, sel}, oldest at the front.
  logic [2:0]  modelQ[$];
  logic [1:0]  expHit;
  logic        expValid;
  logic        expMis;
  logic [31:0] expResolved;
  logic [31:0] expMispred;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input logic rst, input logic push, input logic p0, input logic p1,
                           input logic sel, input logic resolve, input logic taken,
                           input logic flush);
    logic [2:0] e;
    bit         resolveOk;
    bit         pushOk;
    logic       followed;
    if (rst) begin
      modelQ.delete();
      expHit      = 2'b00;
      expValid    = 1'b0;
      expMis      = 1'b0;
      expResolved = '0;
      expMispred  = '0;
      return;
    end
    resolveOk = resolve && (modelQ.size() > 0);
    pushOk    = push && !flush && ((modelQ.size() < DEPTH) || resolveOk);
    expValid  = resolveOk;
    if (resolveOk) begin
      e        = modelQ[0];
      followed = e[0] ? e[2] : e[1];
      expHit   = {e[2] == taken, e[1] == taken};
      expMis   = (followed != taken);
      expResolved = expResolved + 1;
      if (expMis) expMispred = expMispred + 1;
    end
    if (flush) begin
      modelQ.delete();
    end else begin
      if (resolveOk) void'(modelQ.pop_front());
      if (pushOk) modelQ.push_back({p1, p0, sel});
    end
  endtask

  task automatic checkOutput();
    cmp("count", 32'(out_count), 32'(modelQ.size()));
    cmp("full", 32'(out_full), 32'(modelQ.size() == DEPTH));
    cmp("empty", 32'(out_empty), 32'(modelQ.size() == 0));
    cmp("hit_valid", 32'(out_hit_valid), 32'(expValid));
    cmp("hit", 32'(out_hit), 32'(expHit));
    cmp("mispredict", 32'(out_mispredict), 32'(expMis));
`ifdef PRED_RESOLVE_STATS_EN
    cmp("resolved_cnt", out_resolved_cnt, expResolved);
    cmp("mispred_cnt", out_mispred_cnt, expMispred);
`endif
  endtask

  // Drives one cycle of inputs, advances the model, then checks just after the edge.
  task automatic applyStimulus(input logic rst, input logic push, input logic p0, input logic p1,
                               input logic sel, input logic resolve, input logic taken,
                               input logic flush);
    in_Rst     = rst;
    in_push    = push;
    in_pred0   = p0;
    in_pred1   = p1;
    in_sel     = sel;
    in_resolve = resolve;
    in_taken   = taken;
    in_flush   = flush;
    modelStep(rst, push, p0, p1, sel, resolve, taken, flush);
    @(posedge in_Clk);
    #1;
    vectors++;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    in_Rst = 1'b1; in_push = 1'b0; in_pred0 = 1'b0; in_pred1 = 1'b0;
    in_sel = 1'b0; in_resolve = 1'b0; in_taken = 1'b0; in_flush = 1'b0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 1, 1, 1, 1);
    cmp("rst_count", 32'(out_count), 0);
    cmp("rst_empty", 32'(out_empty), 1);
    cmp("rst_full", 32'(out_full), 0);
    cmp("rst_valid", 32'(out_hit_valid), 0);
    cmp("rst_hit", 32'(out_hit), 0);

    // Single entry p1=1 p0=0 sel=0 resolved taken.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    cmp("lit_hit", 32'(out_hit), 32'h2);
    cmp("lit_mis", 32'(out_mispredict), 1);
    cmp("lit_valid", 32'(out_hit_valid), 1);
    idle();
    cmp("lit_hold_hit", 32'(out_hit), 32'h2);
    cmp("lit_hold_valid", 32'(out_hit_valid), 0);

    // Fill, overflow, push+resolve while full, then drain in order.
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, i[0], i[1], i[0] ^ i[1], 0, 0, 0);
    cmp("lit_full", 32'(out_full), 1);
    applyStimulus(0, 1, 1, 1, 1, 0, 0, 0);
    cmp("lit_drop_count", 32'(out_count), 4);
    applyStimulus(0, 1, 1, 1, 1, 1, 0, 0);
    cmp("lit_fullpr_count", 32'(out_count), 4);
    cmp("lit_fullpr_hit", 32'(out_hit), 32'h3);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    cmp("lit_drained", 32'(out_empty), 1);

    // Resolve on empty, then push+resolve on empty.
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
    cmp("lit_empty_res_valid", 32'(out_hit_valid), 0);
    applyStimulus(0, 1, 1, 0, 0, 1, 0, 0);
    cmp("lit_empty_pr_count", 32'(out_count), 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);

    // Three entries, flush with a resolve of the oldest, then flush with a push.
    applyStimulus(0, 1, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
    cmp("lit_flush_valid", 32'(out_hit_valid), 1);
    cmp("lit_flush_hit", 32'(out_hit), 32'h1);
    cmp("lit_flush_mis", 32'(out_mispredict), 1);
    cmp("lit_flush_count", 32'(out_count), 0);
    applyStimulus(0, 1, 1, 1, 1, 0, 0, 1);
    cmp("lit_flushpush_count", 32'(out_count), 0);

    // Ten push/resolve pairs walking the pointers across the wrap.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0);
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1, 1'($urandom), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1'($urandom), 0);

    // Reset with two entries queued and a result pending.
    applyStimulus(0, 1, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 1, 0, 0);
    applyStimulus(1, 1, 1, 1, 1, 1, 1, 1);
    cmp("lit_midrst_count", 32'(out_count), 0);
    cmp("lit_midrst_valid", 32'(out_hit_valid), 0);
`ifdef PRED_RESOLVE_STATS_EN
    cmp("lit_midrst_rcnt", out_resolved_cnt, 0);
    cmp("lit_midrst_mcnt", out_mispred_cnt, 0);
`endif

    // Random traffic with occasional flush and rare reset.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(1'($urandom_range(0, 99) == 0),
                    1'($urandom_range(0, 99) < 60),
                    1'($urandom), 1'($urandom), 1'($urandom),
                    1'($urandom_range(0, 99) < 50),
                    1'($urandom),
                    1'($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pred_resolve_queue.md
PRED_RESOLVE_QUEUE -- requirements
Module: pred_resolve_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of in-flight branch entries; SHALL be a power of two and at least 2.
REQ-002 in_Clk  input  1  single clock; all state updates on the rising edge.
REQ-003 in_Rst  input  1  reset, synchronous and active-high.
REQ-004 in_push  input  1  fetch issues a predicted branch this cycle.
REQ-005 in_pred0 / in_pred1  input  1 each  direction predicted by predictor 0 / predictor 1 (1 = taken).
REQ-006 in_sel  input  1  selector choice used at fetch (0 = predictor 0, 1 = predictor 1).
REQ-007 in_resolve  input  1  execute resolves the oldest outstanding branch this cycle.
REQ-008 in_taken  input  1  actual direction of the resolving branch.
REQ-009 in_flush  input  1  discard all younger outstanding branches.
REQ-010 out_hit  output  2  {pred1 correct, pred0 correct}; feeds the predictor selector's hit input.
REQ-011 out_hit_valid  output  1  out_hit and out_mispredict are valid this cycle.
REQ-012 out_mispredict  output  1  the selected prediction was wrong.
REQ-013 out_full / out_empty  output  1 each  queue occupancy flags.
REQ-014 out_count  output  log2(DEPTH)+1  number of entries held.

Function
REQ-015 Each entry SHALL store {pred1, pred0, sel}; the queue SHALL be FIFO ordered.
REQ-016 A push SHALL be accepted when not full, or when full with in_resolve=1 in the same cycle; otherwise it SHALL be dropped and state SHALL be unchanged.
REQ-017 A resolve SHALL be ignored when empty; out_hit_valid SHALL then be 0 the next cycle.
REQ-018 On an accepted resolve, in the next cycle: out_hit_valid=1, out_hit[k]=(pred_k==in_taken), out_mispredict=((sel?pred1:pred0)!=in_taken); registered, latency 1 cycle.
REQ-019 Without a valid resolve, out_hit_valid SHALL be 0 and out_hit/out_mispredict SHALL hold their last values.
REQ-020 Simultaneous push and resolve SHALL leave out_count unchanged; on an empty queue the resolve SHALL be ignored and the push accepted.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; full is count==DEPTH and empty is count==0.
REQ-022 in_flush SHALL empty the queue on the next edge. A resolve in the same cycle SHALL be processed first and SHALL produce a valid output. A push in the same cycle SHALL be discarded.

Reset
REQ-023 While in_Rst=1: pointers and count SHALL be 0, out_empty=1, out_full=0, out_hit_valid=0, out_hit=2'b00, out_mispredict=0.
REQ-024 Reset SHALL override push, resolve and flush in the same cycle; an output pending from the prior cycle SHALL NOT appear after reset.
REQ-025 Entry storage contents need not be reset.

Configuration
REQ-026 Macro PRED_RESOLVE_STATS_EN.
- Defined: adds outputs out_resolved_cnt[31:0] and out_mispred_cnt[31:0]. Both reset to 0, increment on each accepted resolve and each mispredict respectively, and wrap at 2^32.
- Undefined: these ports and their counters SHALL NOT exist.

Structure
REQ-027 Entry field offsets (SEL, PRED0, PRED1), entry width (3) and DEPTH default SHALL be defined in the shared BPU package/include.
REQ-028 Entry storage and pointers SHALL be a sub-module resolve_fifo. Hit, mispredict and statistics logic SHALL be in the top module.

Verification
REQ-029 Push {p1=1,p0=0,sel=0}, then resolve with taken=1 -> one cycle later: out_hit=2'b10, out_mispredict=1, out_hit_valid=1.
REQ-030 Push 4 entries with DEPTH=4 -> out_full=1; a 5th push alone is dropped; push+resolve while full -> count stays 4, FIFO order preserved.
REQ-031 Resolve on an empty queue -> out_hit_valid=0, count 0; push+resolve on empty -> count 1.
REQ-032 3 entries, flush+resolve in the same cycle -> valid hit for the oldest entry, count 0, out_empty=1; flush+push -> count 0.
REQ-033 Run 10 push/resolve pairs crossing the pointer wrap -> outputs match a reference model in order.
REQ-034 Assert reset mid-stream with 2 entries queued and a resolve pending -> next cycle count 0, out_hit_valid=0; with the macro defined, both counters read 0.
